// File: rtl/tilt_square_seq_pkg.sv
// Shared definitions for the sequential shift-add squarer: default widths,
// the saturation constant for the default result width, and the FSM encoding.
package tilt_square_seq_pkg;

   localparam int IN_W_DEF  = 12;
   localparam int OUT_W_DEF = 22;

   // Largest representable result at the default result width.
   localparam logic [21:0] SAT_VAL = 22'h3FFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/tilt_square_seq_if.sv
// Request/result bundle for tilt_square_seq.
// Handshake: start is a request that the block accepts only in IDLE or DONE;
// a request seen in CALC is dropped, not queued. ready is a one-cycle pulse
// marking a fresh out/sat pair, which then holds until the next pulse.
// busy is high for exactly the cycles spent computing.
interface tilt_square_seq_if #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 22
);

   logic [IN_W-1:0]  in;
   logic             start;
   logic [OUT_W-1:0] out;
   logic             ready;
   logic             busy;
   logic             sat;

   // Requester side: drives operand and start, observes results.
   modport master (
      output in,
      output start,
      input  out,
      input  ready,
      input  busy,
      input  sat
   );

   // Squarer side.
   modport slave (
      input  in,
      input  start,
      output out,
      output ready,
      output busy,
      output sat
   );

endinterface

// File: rtl/tilt_square_seq.sv
// Sequential squarer: one shift-add iteration per cycle over IN_W cycles,
// result saturated to OUT_W bits and held until the next result.
module tilt_square_seq
   import tilt_square_seq_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   tilt_square_seq_if.slave   bus,
   output state_t             dbg_state
);

   localparam int ACC_W = 2 * IN_W;
   localparam int CNT_W = $clog2(IN_W + 1);

   // Default width shares the package constant; other widths saturate to all ones.
   localparam logic [OUT_W-1:0] SAT_OUT =
      (OUT_W == OUT_W_DEF) ? OUT_W'(SAT_VAL) : {OUT_W{1'b1}};

   state_t            state_q;
   state_t            state_d;
   logic [IN_W-1:0]   mcand_q;
   logic [IN_W-1:0]   mplier_q;
   logic [ACC_W-1:0]  acc_q;
   logic [ACC_W-1:0]  acc_nxt;
   logic [ACC_W-1:0]  addend;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  idx;
   logic [OUT_W-1:0]  out_q;
   logic              sat_q;
   logic              accept;
   logic              last_iter;
   logic              acc_over;

   // Iteration datapath: next accumulator value and saturation detect.
   always_comb begin
      accept    = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
      last_iter = (state_q == ST_CALC) && (cnt_q == CNT_W'(1));
      // Counter runs IN_W..1, so the iteration index runs 0..IN_W-1.
      idx       = CNT_W'(IN_W) - cnt_q;
      addend    = {{IN_W{1'b0}}, mcand_q} << idx;
      acc_nxt   = mplier_q[0] ? (acc_q + addend) : acc_q;
      acc_over  = |(acc_nxt >> OUT_W);
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_CALC;
         ST_CALC: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
         ST_DONE: state_d = bus.start ? ST_CALC : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register; reset wins over a coincident start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Operand load, shift-add iteration and result capture on the final iteration.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         sat_q    <= 1'b0;
      end else if (accept) begin
         mcand_q  <= bus.in;
         mplier_q <= bus.in;
         acc_q    <= '0;
         cnt_q    <= CNT_W'(IN_W);
      end else if (state_q == ST_CALC) begin
         acc_q    <= acc_nxt;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - CNT_W'(1);
         if (last_iter) begin
            out_q <= acc_over ? SAT_OUT : acc_nxt[OUT_W-1:0];
            sat_q <= acc_over;
         end
      end
   end

   assign bus.out   = out_q;
   assign bus.sat   = sat_q;
   assign bus.ready = (state_q == ST_DONE);
   assign bus.busy  = (state_q == ST_CALC);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tilt_square_seq.sv
// Directed bench for tilt_square_seq: reset values, latency, saturation
// boundary, ignored start while busy, reset abort and back-to-back starts.
module tb_tilt_square_seq;
   import tilt_square_seq_pkg::*;

   localparam int IN_W  = 12;
   localparam int OUT_W = 22;

   logic   clk;
   logic   reset;
   state_t dbg_state;
   int     checks;
   int     errors;

   tilt_square_seq_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   tilt_square_seq #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver: present an operand with start at edge 0, drop start afterwards.
   // Returns at the falling edge following edge 0.
   task automatic start_op(input logic [IN_W-1:0] val);
      bus.in    = val;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Wait (bounded) for ready; lat is the number of rising edges after the
   // start edge before ready is seen. Returns at a falling edge.
   task automatic wait_ready(output int lat, output bit seen);
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.ready) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   // Count ready pulses over n cycles.
   task automatic count_ready(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.ready) pulses++;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.in    = '0;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.out !== 22'd0) begin
         errors++; $display("FAIL reset_out: got %0h expected 0", bus.out);
      end
      checks++;
      if (bus.sat !== 1'b0) begin
         errors++; $display("FAIL reset_sat: got %b expected 0", bus.sat);
      end
      checks++;
      if (bus.ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
      end
      checks++;
      if (dbg_state !== ST_IDLE) begin
         errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   // in = 0 still takes the full latency; ready lasts one cycle.
   task automatic test_zero();
      int lat;
      bit seen;
      start_op(12'd0);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL zero_busy: got %b expected 1", bus.busy);
      end
      wait_ready(lat, seen);
      // ready is visible in the cycle sampled by edge IN_W+1 (13).
      checks++;
      if (!seen || lat != 12) begin
         errors++; $display("FAIL zero_latency: got %0d (seen %b) expected 12", lat, seen);
      end
      checks++;
      if (bus.out !== 22'd0 || bus.sat !== 1'b0) begin
         errors++; $display("FAIL zero_result: got out=%0h sat=%b expected out=0 sat=0", bus.out, bus.sat);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.ready !== 1'b0 || dbg_state !== ST_IDLE) begin
         errors++; $display("FAIL zero_pulse: got ready=%b state=%0d expected ready=0 state=0", bus.ready, dbg_state);
      end
   endtask

   // Largest operand whose square still fits in 22 bits.
   task automatic test_max_unsat();
      int lat;
      bit seen;
      start_op(12'd2047);
      wait_ready(lat, seen);
      checks++;
      if (!seen || bus.out !== 22'h3FF001 || bus.sat !== 1'b0) begin
         errors++; $display("FAIL max_unsat: got out=%0h sat=%b seen=%b expected out=3ff001 sat=0", bus.out, bus.sat, seen);
      end
   endtask

   // First saturating operand, then the largest operand.
   task automatic test_saturate();
      int lat;
      bit seen;
      start_op(12'd2048);
      wait_ready(lat, seen);
      checks++;
      if (!seen || bus.out !== 22'h3FFFFF || bus.sat !== 1'b1) begin
         errors++; $display("FAIL sat_2048: got out=%0h sat=%b seen=%b expected out=3fffff sat=1", bus.out, bus.sat, seen);
      end
      start_op(12'd4095);
      wait_ready(lat, seen);
      checks++;
      if (!seen || bus.out !== 22'h3FFFFF || bus.sat !== 1'b1) begin
         errors++; $display("FAIL sat_4095: got out=%0h sat=%b seen=%b expected out=3fffff sat=1", bus.out, bus.sat, seen);
      end
   endtask

   // Start at edge 5 with a new operand must be dropped.
   task automatic test_busy_ignore();
      int lat;
      bit seen;
      int pulses;
      start_op(12'd100);
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      bus.in    = 12'd7;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.out !== 22'h3FFFFF || bus.sat !== 1'b1) begin
         errors++; $display("FAIL busy_hold: got busy=%b out=%0h sat=%b expected busy=1 out=3fffff sat=1", bus.busy, bus.out, bus.sat);
      end
      wait_ready(lat, seen);
      checks++;
      if (!seen || lat != 7) begin
         errors++; $display("FAIL busy_latency: got %0d (seen %b) expected 7", lat, seen);
      end
      checks++;
      if (bus.out !== 22'd10000 || bus.sat !== 1'b0) begin
         errors++; $display("FAIL busy_result: got out=%0d sat=%b expected out=10000 sat=0", bus.out, bus.sat);
      end
      count_ready(20, pulses);
      checks++;
      if (pulses != 0) begin
         errors++; $display("FAIL busy_no_second: got %0d pulses expected 0", pulses);
      end
   endtask

   // Reset mid-calculation aborts; start during reset is ignored.
   task automatic test_reset_abort();
      int lat;
      bit seen;
      int pulses;
      start_op(12'd3000);
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.out !== 22'd0 || bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.sat !== 1'b0) begin
         errors++; $display("FAIL abort_immediate: got out=%0h busy=%b ready=%b sat=%b expected all 0", bus.out, bus.busy, bus.ready, bus.sat);
      end
      bus.in    = 12'd9;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset     = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || dbg_state !== ST_IDLE) begin
         errors++; $display("FAIL abort_start_in_reset: got busy=%b state=%0d expected busy=0 state=0", bus.busy, dbg_state);
      end
      count_ready(20, pulses);
      checks++;
      if (pulses != 0) begin
         errors++; $display("FAIL abort_no_ready: got %0d pulses expected 0", pulses);
      end
      start_op(12'd5);
      wait_ready(lat, seen);
      checks++;
      if (!seen || lat != 12 || bus.out !== 22'd25 || bus.sat !== 1'b0) begin
         errors++; $display("FAIL abort_restart: got out=%0d sat=%b lat=%0d seen=%b expected out=25 sat=0 lat=12", bus.out, bus.sat, lat, seen);
      end
   endtask

   // Start in the ready cycle is accepted: results 13 cycles apart.
   task automatic test_back_to_back();
      int lat;
      bit seen;
      start_op(12'd3);
      wait_ready(lat, seen);
      checks++;
      if (!seen || bus.out !== 22'd9) begin
         errors++; $display("FAIL b2b_first: got out=%0d seen=%b expected 9", bus.out, seen);
      end
      start_op(12'd4);
      checks++;
      if (bus.busy !== 1'b1 || bus.ready !== 1'b0 || bus.out !== 22'd9) begin
         errors++; $display("FAIL b2b_accept: got busy=%b ready=%b out=%0d expected busy=1 ready=0 out=9", bus.busy, bus.ready, bus.out);
      end
      wait_ready(lat, seen);
      // Start edge is the old ready cycle's edge, so 12 more edges = 13 cycles apart.
      checks++;
      if (!seen || lat != 12 || bus.out !== 22'd16) begin
         errors++; $display("FAIL b2b_second: got out=%0d lat=%0d seen=%b expected out=16 lat=12", bus.out, lat, seen);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_zero();
      test_max_unsat();
      test_saturate();
      test_busy_ignore();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
